ysyx_23060191_wbu: RTL
======================

# ysyx_23060191_wbu

Write-back unit sitting between the execute/load-store stages and the general-purpose register file. It accepts one retiring instruction at a time over a valid/ready handshake, waits for load data from the LSU when needed, aligns and sign/zero-extends load data, and issues a single-cycle register-file write. It also raises a one-cycle commit pulse that releases the fetch stage for the next instruction.

## Interface
- `XLEN`, default 32: datapath width, equal to `CPU_WIDTH`.
- `TIMEOUT`, default 255: LSU wait limit in cycles. Used only when the timeout feature is compiled in.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `i_valid` input 1: upstream instruction valid.
- `o_ready` output 1: WBU can accept an instruction.
- `i_wr_en` input 1: instruction writes rd.
- `i_rd` input 5: destination register index.
- `i_alu_res` input XLEN: ALU or CSR result for non-loads.
- `i_is_load` input 1: instruction is a load.
- `i_funct3` input 3: load type.
- `i_byte_off` input 2: load address[1:0].
- `i_lsu_rvalid` input 1: LSU read data valid.
- `i_lsu_rdata` input XLEN: raw aligned memory word.
- `o_wr_en_Rd` output 1: GPR write enable.
- `o_addr_Rd` output 5: GPR write address.
- `o_data_Rd` output XLEN: GPR write data.
- `o_commit` output 1: instruction retired, one-cycle pulse.
- `o_err` output 1: LSU timeout, one-cycle pulse. Tied to 0 when the timeout feature is compiled out.

## Operation
- FSM states: `IDLE`, `WAIT_MEM`, `WRITE`.
- **IDLE.** `o_ready=1`. A handshake (`i_valid && o_ready`) captures `i_wr_en`, `i_rd`, `i_funct3`, `i_byte_off`, and `i_alu_res` into holding registers.
  - Load: go to `WAIT_MEM`.
  - Otherwise: go to `WRITE`.
- **WAIT_MEM.** `o_ready=0`. When `i_lsu_rvalid=1`, capture the formatted load data and go to `WRITE`.
- **WRITE.** `o_ready=0`.
  - `o_wr_en_Rd` = captured `wr_en && rd!=0`. Writes to x0 are suppressed here.
  - `o_addr_Rd` = rd, `o_data_Rd` = held data, `o_commit=1`.
  - Next state is `IDLE` unconditionally.
- **Load formatting.** Byte lane = `rdata >> (8*off)`; half lane = `rdata >> (16*off[1])`.
  - `000` LB: sign-extend byte.
  - `001` LH: sign-extend half.
  - `100` LBU: zero-extend byte.
  - `101` LHU: zero-extend half.
  - `010` and all other codes: full word.
  - Misaligned halves (`off=1` or `off=3`) use `off[1]` only; no trap is raised.
- **Ignored inputs.**
  - `i_lsu_rvalid` in `IDLE` or `WRITE` is ignored and no data is captured.
  - `i_valid` while `o_ready=0` is ignored; upstream must hold its payload stable until the handshake.
- **Reset.** A reset in any state returns the FSM to `IDLE` on the next edge. Any held instruction is discarded with no write and no commit.

## Timing
- **Reset values.**
  - While `rst=1`: `o_ready=0`.
  - On the edge after reset: `o_wr_en_Rd=0`, `o_addr_Rd=0`, `o_data_Rd=0`, `o_commit=0`, `o_err=0`, state `IDLE`.
  - `o_ready=1` from the first cycle after `rst` deasserts.
- **Outputs are registered.** Write and commit outputs are driven from state registers; there is no combinational path from any input to `o_wr_en_Rd`, `o_data_Rd`, or `o_commit`.
- **Non-load latency.** Handshake in cycle N gives `WRITE` in cycle N+1; GPR captures on the edge ending N+1.
- **Load latency.** Earliest `i_lsu_rvalid` is cycle N+1. Valid in cycle M gives `WRITE` in cycle M+1.
- **Throughput.** Maximum is one instruction per 2 cycles for non-loads; the next accept is in cycle N+2.
- `o_wr_en_Rd` and `o_commit` are each high for exactly one cycle per retired instruction.

## Configuration
- Macro: `YSYX_23060191_WBU_TIMEOUT_EN`.
- **Defined.**
  - An 8-bit-or-wider counter clears on entry to `WAIT_MEM` and increments each cycle in that state.
  - If it reaches `TIMEOUT` with no `i_lsu_rvalid`, go to `WRITE` with the write suppressed (`o_wr_en_Rd=0`) and `o_commit=1`; `o_err=1` in that same cycle.
  - If `i_lsu_rvalid` arrives in the same cycle the counter reaches `TIMEOUT`, the data wins and there is no error.
- **Undefined.**
  - No counter; `WAIT_MEM` waits indefinitely.
  - `o_err` is constant 0.

## Test plan
- ALU write: handshake `rd=5`, `alu_res=0x12345678`, `wr_en=1` -> next cycle `o_wr_en_Rd=1`, `o_addr_Rd=5`, `o_data_Rd=0x12345678`, `o_commit=1`; `o_ready=1` one cycle later.
- x0 suppression: `rd=0`, `wr_en=1` -> `o_wr_en_Rd=0`, `o_commit=1`.
- Load formatting with `rdata=0x80F17F02`:
  - LB `off=2` -> `0xFFFFFFF1`.
  - LBU `off=3` -> `0x00000080`.
  - LH `off=2` -> `0xFFFF80F1`.
  - LHU `off=0` -> `0x00007F02`.
  - LW -> `0x80F17F02`.
- Load wait: `i_lsu_rvalid` delayed 7 cycles -> `o_ready=0` throughout; write occurs exactly 1 cycle after `rvalid`; a stray `rvalid` in `IDLE` produces no write.
- Reset mid-load: assert `rst` in `WAIT_MEM`, then `rvalid` -> no write, no commit; `o_ready=1` after `rst` drops.
- Timeout (with macro, `TIMEOUT=4`): no `rvalid` -> `o_err=1` and `o_commit=1` with `o_wr_en_Rd=0` after the 4-cycle wait; without the macro, `o_err` stays 0 and the FSM waits.

Source files
------------

// File: rtl/ysyx_23060191_wbu_if.sv
// ============================================================================
//  Module   : ysyx_23060191_wbu_if
//  Purpose  : Bundles every non-clock/reset signal of the write-back unit:
//             upstream retire handshake and payload, LSU read-data return,
//             GPR write port, commit and error pulses.
//  Ports    : (interface signals, named from the WBU's point of view)
//             i_valid/o_ready       upstream handshake
//             i_wr_en, i_rd, i_alu_res, i_is_load, i_funct3, i_byte_off
//                                   retiring instruction payload
//             i_lsu_rvalid, i_lsu_rdata
//                                   LSU load data return
//             o_wr_en_Rd, o_addr_Rd, o_data_Rd
//                                   GPR write port
//             o_commit, o_err       retire pulse / LSU timeout pulse
//  Modports : slave  - the WBU itself
//             master - the environment driving the WBU
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_23060191_wbu_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic            i_wr_en;
    logic [4:0]      i_rd;
    logic [XLEN-1:0] i_alu_res;
    logic            i_is_load;
    logic [2:0]      i_funct3;
    logic [1:0]      i_byte_off;
    logic            i_lsu_rvalid;
    logic [XLEN-1:0] i_lsu_rdata;
    logic            o_wr_en_Rd;
    logic [4:0]      o_addr_Rd;
    logic [XLEN-1:0] o_data_Rd;
    logic            o_commit;
    logic            o_err;

    modport slave (
        input  i_valid, i_wr_en, i_rd, i_alu_res, i_is_load, i_funct3,
               i_byte_off, i_lsu_rvalid, i_lsu_rdata,
        output o_ready, o_wr_en_Rd, o_addr_Rd, o_data_Rd, o_commit, o_err
    );

    modport master (
        output i_valid, i_wr_en, i_rd, i_alu_res, i_is_load, i_funct3,
               i_byte_off, i_lsu_rvalid, i_lsu_rdata,
        input  o_ready, o_wr_en_Rd, o_addr_Rd, o_data_Rd, o_commit, o_err
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_23060191_wbu.sv
// ============================================================================
//  Module   : ysyx_23060191_wbu
//  Purpose  : Write-back unit. Accepts one retiring instruction at a time,
//             waits for LSU data on loads, aligns and extends load data and
//             issues a single-cycle GPR write plus a one-cycle commit pulse.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - ysyx_23060191_wbu_if.slave (handshake, payload, LSU
//                    return, GPR write port, o_commit, o_err)
//  Params   : XLEN    - datapath width
//             TIMEOUT - LSU wait limit in cycles (timeout build only)
//  Options  : `define YSYX_23060191_WBU_TIMEOUT_EN to add the LSU wait
//             timeout; otherwise WAIT_MEM waits forever and o_err is 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060191_wbu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  wire                       clk,
    input  wire                       rst,
    ysyx_23060191_wbu_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            wr_en_q, wr_en_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      off_q, off_d;
    logic [XLEN-1:0] data_q, data_d;

    // ------------------------------------------------------------------
    // Load formatting. Halves use only off[1]: misaligned halves simply
    // read the lower/upper half of the word, no trap.
    // ------------------------------------------------------------------
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;

    assign w_byte = 8'(bus.i_lsu_rdata >> {off_q, 3'b000});
    assign w_half = 16'(bus.i_lsu_rdata >> {off_q[1], 4'b0000});

    always_comb begin
        w_load_data = bus.i_lsu_rdata;
        case (funct3_q)
            3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_data = bus.i_lsu_rdata;
        endcase
    end

`ifdef YSYX_23060191_WBU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    // Counter value in the last permitted waiting cycle; the increment out
    // of this cycle would reach TIMEOUT.
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    // ------------------------------------------------------------------
    // Next-state / datapath capture
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        wr_en_d  = wr_en_q;
        rd_d     = rd_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        data_d   = data_q;
`ifdef YSYX_23060191_WBU_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    wr_en_d  = bus.i_wr_en;
                    rd_d     = bus.i_rd;
                    funct3_d = bus.i_funct3;
                    off_d    = bus.i_byte_off;
                    data_d   = bus.i_alu_res;
                    state_d  = bus.i_is_load ? WAIT_MEM : WRITE;
`ifdef YSYX_23060191_WBU_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            WAIT_MEM: begin
                // Data arriving in the final waiting cycle beats the timeout.
                if (bus.i_lsu_rvalid) begin
                    data_d  = w_load_data;
                    state_d = WRITE;
                end
`ifdef YSYX_23060191_WBU_TIMEOUT_EN
                else if (cnt_q == c_timeout_last) begin
                    err_d   = 1'b1;
                    state_d = WRITE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_en_q  <= 1'b0;
            rd_q     <= 5'd0;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
            data_q   <= '0;
`ifdef YSYX_23060191_WBU_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_en_q  <= wr_en_d;
            rd_q     <= rd_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            data_q   <= data_d;
`ifdef YSYX_23060191_WBU_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from flops only (rst gates o_ready so upstream
    // sees "not ready" for the whole reset window).
    // ------------------------------------------------------------------
    logic w_write;
    assign w_write = (state_q == WRITE);

    assign bus.o_ready  = (state_q == IDLE) && !rst;
    assign bus.o_commit = w_write;
    assign bus.o_addr_Rd = rd_q;
    assign bus.o_data_Rd = data_q;

`ifdef YSYX_23060191_WBU_TIMEOUT_EN
    assign bus.o_wr_en_Rd = w_write && wr_en_q && (rd_q != 5'd0) && !err_q;
    assign bus.o_err      = err_q;
`else
    assign bus.o_wr_en_Rd = w_write && wr_en_q && (rd_q != 5'd0);
    assign bus.o_err      = 1'b0;
`endif

endmodule

`default_nettype wire
